// File: rtl/aes_pkg.sv
// Shared constants and FSM state encoding for the AES word loader.
package aes_pkg;

   localparam int AES_BLOCK_W     = 128;
   localparam int AES_WORD_W      = 32;
   localparam int WORDS_PER_BLOCK = 4;

   typedef enum logic [2:0] {
      S_KEY,
      S_PT,
      S_START,
      S_WAIT,
      S_DRAIN
   } state_t;

endpackage

// File: rtl/word_swap32.sv
// Optional byte reversal of one 32-bit word, giving the CPU a little-endian view.
module word_swap32
   import aes_pkg::*;
#(
   parameter bit ENABLE = 1'b0
) (
   input  logic [AES_WORD_W-1:0] word,
   output logic [AES_WORD_W-1:0] swapped
);

   assign swapped = ENABLE ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;

endmodule

// File: rtl/aes_word_loader.sv
// Word-stream adapter around the AES-128 core: loads key and plaintext 32 bits
// at a time, fires the core, and streams the ciphertext back out with a watchdog.
module aes_word_loader
   import aes_pkg::*;
#(
   parameter bit BYTE_SWAP      = 1'b0,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_WORD_W-1:0]  in_data,
   output logic [AES_BLOCK_W-1:0] key_out,
   output logic [AES_BLOCK_W-1:0] plain_text_out,
   output logic                   start,
   input  logic                   core_done,
   input  logic [AES_BLOCK_W-1:0] core_dout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_WORD_W-1:0]  out_data,
   output logic                   busy,
   output logic                   error
);

   // The timer counts from 0 on WAIT entry; hitting this value means the
   // incremented count would reach TIMEOUT_CYCLES-1.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 2);

   state_t                 state, state_nxt;
   logic [1:0]             word_cnt;
   logic [7:0]             timer;
   logic [AES_BLOCK_W-1:0] key_reg, pt_reg, result_reg;
   logic                   error_reg;
   logic [AES_WORD_W-1:0]  in_word, result_word, out_word;
   logic [6:0]             slot_lsb;
   logic                   last_word, timer_expired;

   // Word 0 lives in the top 32 bits, so the slot offset is the inverted counter.
   assign slot_lsb      = {~word_cnt, 5'd0};
   assign last_word     = (word_cnt == 2'd3);
   assign timer_expired = (timer == TIMER_LAST);
   assign result_word   = result_reg[slot_lsb +: AES_WORD_W];

   word_swap32 #(.ENABLE(BYTE_SWAP)) u_in_swap (
      .word    (in_data),
      .swapped (in_word)
   );

   word_swap32 #(.ENABLE(BYTE_SWAP)) u_out_swap (
      .word    (result_word),
      .swapped (out_word)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_KEY;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake-qualified branches test in_valid/out_ready directly since the
   // matching ready/valid is implied by the state itself.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      start     = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         S_KEY: begin
            in_ready = 1'b1;
            if (in_valid && last_word) state_nxt = S_PT;
         end
         S_PT: begin
            in_ready = 1'b1;
            if (in_valid && last_word) state_nxt = S_START;
         end
         S_START: begin
            start     = 1'b1;
            busy      = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (core_done)          state_nxt = S_DRAIN;
            else if (timer_expired) state_nxt = S_KEY;
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready && last_word) state_nxt = S_KEY;
         end
         default: state_nxt = S_KEY;
      endcase
      if (clear) state_nxt = S_KEY;
   end

   // Datapath: word counter, watchdog timer, block registers and sticky error.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word_cnt   <= '0;
         timer      <= '0;
         key_reg    <= '0;
         pt_reg     <= '0;
         result_reg <= '0;
         error_reg  <= 1'b0;
      end else if (clear) begin
         word_cnt <= '0;
         timer    <= '0;
      end else begin
         case (state)
            S_KEY: begin
               if (in_valid) begin
                  key_reg[slot_lsb +: AES_WORD_W] <= in_word;
                  word_cnt <= word_cnt + 2'd1;
                  if (word_cnt == 2'd0) error_reg <= 1'b0;
               end
            end
            S_PT: begin
               if (in_valid) begin
                  pt_reg[slot_lsb +: AES_WORD_W] <= in_word;
                  word_cnt <= word_cnt + 2'd1;
               end
            end
            S_START: timer <= '0;
            S_WAIT: begin
               timer <= timer + 8'd1;
               if (core_done) begin
                  result_reg <= core_dout;
               end else if (timer_expired) begin
                  error_reg <= 1'b1;
                  word_cnt  <= '0;
               end
            end
            S_DRAIN: begin
               if (out_ready) word_cnt <= word_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign key_out        = key_reg;
   assign plain_text_out = pt_reg;
   assign out_data       = out_valid ? out_word : '0;
   assign error          = error_reg;

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader: a plain and a byte-swapped instance
// share one stimulus stream and are compared against a block-level model.
module tb_aes_word_loader;

   localparam int TIMEOUT = 16;

   typedef struct {
      logic [255:0] in_bits;
      logic [127:0] dout;
      int           done_delay;
      int           clear_after_in;
      int           clear_after_out;
      bit           stall_mid_drain;
      logic [127:0] exp_key;
      logic [127:0] exp_pt;
      logic [127:0] exp_out;
   } vec_t;

   logic         clock = 1'b0;
   logic         reset;
   logic         clear;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         core_done;
   logic [127:0] core_dout;
   logic         out_ready;

   logic         in_ready, start, out_valid, busy, error;
   logic [127:0] key_out, plain_text_out;
   logic [31:0]  out_data;
   logic         in_ready_sw, start_sw, out_valid_sw, busy_sw, error_sw;
   logic [127:0] key_out_sw, plain_text_out_sw;
   logic [31:0]  out_data_sw;

   int   errors = 0;
   int   checks = 0;
   logic exp_error = 1'b0;
   vec_t vecs[8];

   aes_word_loader #(.BYTE_SWAP(1'b0), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .key_out(key_out), .plain_text_out(plain_text_out), .start(start),
      .core_done(core_done), .core_dout(core_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .error(error)
   );

   aes_word_loader #(.BYTE_SWAP(1'b1), .TIMEOUT_CYCLES(TIMEOUT)) dut_sw (
      .clock(clock), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready_sw), .in_data(in_data),
      .key_out(key_out_sw), .plain_text_out(plain_text_out_sw), .start(start_sw),
      .core_done(core_done), .core_dout(core_dout),
      .out_valid(out_valid_sw), .out_ready(out_ready), .out_data(out_data_sw),
      .busy(busy_sw), .error(error_sw)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] bench did not terminate");
   end

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [127:0] bswapBlock(input logic [127:0] b);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[32*i +: 32] = bswap(b[32*i +: 32]);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkFlag(input string name, input logic actual, input logic expected);
      checkOutput(name, 128'(actual), 128'(expected));
   endtask

   task automatic nextCycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   // One full transaction: load 8 words, run the behavioural core, drain 4 words.
   task automatic applyStimulus(input vec_t v);
      int          idx, cyc, limit, got, stall_left, bad;
      bit          stall_used, was_stalled;
      logic [31:0] held, held_sw, exp_word;

      checkFlag("error_before_load", error, exp_error);
      idx = 0; cyc = 0; bad = 0;
      while (idx < 8 && cyc < 400 && !(v.clear_after_in != 0 && idx == v.clear_after_in)) begin
         if (in_ready !== 1'b1 || in_ready_sw !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad++;
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = v.in_bits[255 - 32*idx -: 32];
         @(posedge clock);
         if (in_valid) idx++;
         @(negedge clock);
         if (in_valid && idx == 1) begin
            checkFlag("error_cleared_by_key", error, 1'b0);
            checkFlag("error_cleared_by_key_sw", error_sw, 1'b0);
            exp_error = 1'b0;
         end
         in_valid = 1'b0;
         cyc++;
      end
      checkOutput("load_state", 128'(bad), 128'(0));

      if (v.clear_after_in != 0) begin
         checkOutput("words_before_clear", 128'(idx), 128'(v.clear_after_in));
         clear = 1'b1;
         nextCycle();
         clear = 1'b0;
         checkFlag("clear_load_in_ready", in_ready, 1'b1);
         checkFlag("clear_load_start", start, 1'b0);
         return;
      end
      checkOutput("words_loaded", 128'(idx), 128'(8));
      if (idx != 8) return;

      checkFlag("start_pulse", start, 1'b1);
      checkFlag("start_busy", busy, 1'b1);
      checkFlag("start_in_ready", in_ready, 1'b0);
      checkOutput("key_out", key_out, v.exp_key);
      checkOutput("plain_text_out", plain_text_out, v.exp_pt);
      checkOutput("key_out_swapped", key_out_sw, bswapBlock(v.exp_key));
      checkOutput("plain_text_out_swapped", plain_text_out_sw, bswapBlock(v.exp_pt));

      limit = (v.done_delay == 0) ? TIMEOUT - 1 : v.done_delay;
      bad = 0;
      for (int k = 1; k <= limit; k++) begin
         nextCycle();
         if (start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0 || error !== 1'b0) bad++;
         if (k == v.done_delay) begin
            core_done = 1'b1;
            core_dout = v.dout;
         end
      end
      nextCycle();
      core_done = 1'b0;
      core_dout = {$urandom, $urandom, $urandom, $urandom};
      checkOutput("wait_state", 128'(bad), 128'(0));

      if (v.done_delay == 0) begin
         checkFlag("timeout_error", error, 1'b1);
         checkFlag("timeout_error_sw", error_sw, 1'b1);
         checkFlag("timeout_in_ready", in_ready, 1'b1);
         checkFlag("timeout_out_valid", out_valid, 1'b0);
         checkFlag("timeout_busy", busy, 1'b0);
         exp_error = 1'b1;
         core_done = 1'b1;
         nextCycle();
         core_done = 1'b0;
         checkFlag("late_done_ignored", out_valid, 1'b0);
         checkFlag("late_done_in_ready", in_ready, 1'b1);
         return;
      end
      checkFlag("done_out_valid", out_valid, 1'b1);
      checkFlag("done_error", error, 1'b0);

      got = 0; cyc = 0; bad = 0; stall_left = 0; stall_used = 1'b0; was_stalled = 1'b0;
      held = '0; held_sw = '0;
      while (got < 4 && cyc < 200 && !(v.clear_after_out != 0 && got == v.clear_after_out)) begin
         if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) bad++;
         if (was_stalled && (out_data !== held || out_data_sw !== held_sw)) bad++;
         if (v.stall_mid_drain && got == 2 && !stall_used) begin
            stall_left = 5;
            stall_used = 1'b1;
         end
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = ($urandom_range(0, 2) != 0);
         end
         held    = out_data;
         held_sw = out_data_sw;
         @(posedge clock);
         if (out_ready) begin
            exp_word = v.exp_out[127 - 32*got -: 32];
            checkOutput($sformatf("out_word%0d", got), 128'(held), 128'(exp_word));
            checkOutput($sformatf("out_word%0d_swapped", got), 128'(held_sw), 128'(bswap(exp_word)));
            got++;
         end
         was_stalled = !out_ready;
         @(negedge clock);
         out_ready = 1'b0;
         cyc++;
      end
      checkOutput("drain_state", 128'(bad), 128'(0));

      if (v.clear_after_out != 0) begin
         checkOutput("words_before_clear_out", 128'(got), 128'(v.clear_after_out));
         clear = 1'b1;
         nextCycle();
         clear = 1'b0;
         checkFlag("clear_drain_out_valid", out_valid, 1'b0);
         checkFlag("clear_drain_in_ready", in_ready, 1'b1);
         checkFlag("clear_drain_busy", busy, 1'b0);
         return;
      end
      checkOutput("drain_count", 128'(got), 128'(4));
      checkFlag("after_drain_out_valid", out_valid, 1'b0);
      checkFlag("after_drain_in_ready", in_ready, 1'b1);
      checkFlag("after_drain_busy", busy, 1'b0);
   endtask

   function automatic vec_t makeVec(input logic [255:0] in_bits, input logic [127:0] dout, input int delay);
      vec_t v;
      v.in_bits         = in_bits;
      v.dout            = dout;
      v.done_delay      = delay;
      v.clear_after_in  = 0;
      v.clear_after_out = 0;
      v.stall_mid_drain = 1'b0;
      v.exp_key         = in_bits[255:128];
      v.exp_pt          = in_bits[127:0];
      v.exp_out         = dout;
      return v;
   endfunction

   function automatic logic [255:0] randomWords();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [127:0] randomBlock();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      core_done = 1'b0; core_dout = '0; out_ready = 1'b0;

      vecs[0] = makeVec({32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                         32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff},
                        128'h69c4e0d86a7b0430d8cdb78070b4c55a, 12);
      vecs[0].exp_key = 128'h000102030405060708090a0b0c0d0e0f;
      vecs[0].exp_pt  = 128'h00112233445566778899aabbccddeeff;
      vecs[0].exp_out = {32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
      vecs[0].stall_mid_drain = 1'b1;
      vecs[1] = makeVec(randomWords(), randomBlock(), TIMEOUT - 1);
      vecs[2] = makeVec(randomWords(), randomBlock(), 0);
      vecs[3] = makeVec(randomWords(), randomBlock(), $urandom_range(1, TIMEOUT - 2));
      vecs[3].stall_mid_drain = 1'b1;
      vecs[4] = makeVec(randomWords(), randomBlock(), 5);
      vecs[4].clear_after_in = 6;
      vecs[5] = makeVec(randomWords(), randomBlock(), 3);
      vecs[5].clear_after_out = 2;
      vecs[6] = vecs[0];
      vecs[6].stall_mid_drain = 1'b0;
      vecs[7] = makeVec(randomWords(), randomBlock(), 1);

      @(negedge clock);
      checkFlag("reset_in_ready", in_ready, 1'b1);
      checkFlag("reset_start", start, 1'b0);
      checkFlag("reset_out_valid", out_valid, 1'b0);
      checkFlag("reset_busy", busy, 1'b0);
      checkFlag("reset_error", error, 1'b0);
      checkOutput("reset_key_out", key_out, 128'h0);
      checkOutput("reset_out_data", 128'(out_data), 128'h0);
      reset = 1'b1;
      nextCycle();

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Async reset while the core is busy, then a stray done must not revive it.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = vecs[7].in_bits[255 - 32*i -: 32];
         nextCycle();
      end
      in_valid = 1'b0;
      checkFlag("pre_reset_start", start, 1'b1);
      nextCycle();
      nextCycle();
      #2 reset = 1'b0;
      #1;
      checkFlag("async_reset_in_ready", in_ready, 1'b1);
      checkFlag("async_reset_busy", busy, 1'b0);
      checkFlag("async_reset_out_valid", out_valid, 1'b0);
      checkOutput("async_reset_key_out", key_out, 128'h0);
      checkOutput("async_reset_plain_text_out", plain_text_out_sw, 128'h0);
      @(negedge clock);
      reset = 1'b1;
      core_done = 1'b1;
      core_dout = randomBlock();
      nextCycle();
      core_done = 1'b0;
      checkFlag("post_reset_done_out_valid", out_valid, 1'b0);
      checkFlag("post_reset_done_in_ready", in_ready, 1'b1);
      checkOutput("post_reset_out_data", 128'(out_data), 128'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
- Upstream/downstream adapter for the AES-128 encryption datapath and controller.
- Collects 4 key words then 4 plaintext words from the PicoRV32 coprocessor side over a 32-bit valid/ready stream, and presents 128-bit key and plaintext to the core.
- Pulses the core start/init, waits for the core's done pulse, and returns the 128-bit ciphertext as 4 words over a 32-bit valid/ready stream.
- Includes a watchdog so a hung core cannot lock up the CPU.

Parameters:
- BYTE_SWAP, 0: if 1, byte-reverse each 32-bit word on input and output (little-endian CPU view).
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the error is flagged; legal range 2..255.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous soft abort.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  32  input word.
- key_out  out  128  assembled key to core.
- plain_text_out  out  128  assembled plaintext to core.
- start  out  1  one-cycle pulse to core init.
- core_done  in  1  one-cycle pulse from core when Dout is valid.
- core_dout  in  128  ciphertext from core.
- out_valid  out  1  output word valid.
- out_ready  in  1  output word consumed when out_valid & out_ready.
- out_data  out  32  output word.
- busy  out  1  high in START, WAIT and DRAIN.
- error  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0, async): state KEY, word counter 0, timer 0, key/plaintext/result registers 0, error 0. All outputs 0 except in_ready=1, which follows from state KEY.
- Word order is MSW first: word 0 maps to bits [127:96] and word 3 to bits [31:0], for key, plaintext and result alike.
- State KEY (in_ready=1): each handshake writes the word selected by the 2-bit counter and increments the counter. The 4th word wraps the counter to 0 and moves to PT. The first key word accepted clears error.
- State PT (in_ready=1): same, writing the plaintext register. The 4th word moves to START.
- State START (in_ready=0): start=1 for exactly one cycle. key_out and plain_text_out are stable here and hold until overwritten by the next load. Next state WAIT; timer cleared.
- State WAIT (in_ready=0): timer increments each cycle.
  - core_done=1: latch core_dout into the result register, go to DRAIN.
  - Timer reaches TIMEOUT_CYCLES-1 without done: set error, go to KEY with counter 0 and no output words.
  - core_done in the same cycle as the timeout: done wins, error stays 0.
- State DRAIN: out_valid=1, out_data = result word[counter]. Each handshake increments the counter. The 4th word moves to KEY. out_data must not change while out_valid=1 and out_ready=0.
- core_done outside WAIT is ignored; the result register is unchanged.
- Latency: 8th input handshake at cycle N gives start=1 at N+1. core_done at cycle M gives out_valid=1 at M+1.
- start, in_ready, out_valid and busy are Moore decodes of the state register (no combinational path from inputs).
- clear=1 has priority over all other events: state KEY, counter 0, timer 0, out_valid drops next cycle. The pending result is discarded; error and data registers are kept.
- Async reset mid-operation (any state) gives reset values immediately; a core_done arriving afterwards is ignored.
- BYTE_SWAP=1 reverses bytes [7:0]<->[31:24] and [15:8]<->[23:16] per word on in_data before storage and on out_data after selection. Word order is unaffected.

Decomposition:
- Shared package aes_pkg: state encoding (S_KEY, S_PT, S_START, S_WAIT, S_DRAIN), AES_BLOCK_W=128, AES_WORD_W=32, WORDS_PER_BLOCK=4.
- Sub-module word_swap32: combinational byte reversal used on both input and output paths, enabled by BYTE_SWAP.
- Everything else lives in one module.

Test Plan:
- FIPS-197 vector: key words 00010203,04050607,08090a0b,0c0d0e0f, then plaintext 00112233,44556677,8899aabb,ccddeeff, with a behavioural core raising done 12 cycles after start -> key_out=000102...0f, plain_text_out=0011...ff, one start pulse, output words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a in order.
- Backpressure: in_valid toggled randomly and out_ready held 0 for 5 cycles mid-drain -> no word lost or duplicated; out_data is stable while stalled.
- Watchdog with TIMEOUT_CYCLES=16 and core never done -> error=1 exactly 15 cycles after WAIT entry, state KEY, out_valid never asserted. Next key word accepted -> error=0.
- core_done in the exact timeout cycle -> result drained, error=0.
- clear asserted after 6 input words, and separately after 2 output words -> returns to KEY. A fresh 8-word load gives a correct single start and full 4-word drain.
- BYTE_SWAP=1: input 03020100 -> key_out[127:96]=00010203. Output word 69c4e0d8 appears as d8e0c469. Also: async reset in WAIT followed by a late core_done -> all outputs at reset values, no out_valid.
